// File: rtl/rr_arbiter_mux_if.sv
// Handshake bundle between N_CH producer ports and one consumer, as seen by the arbiter mux.
// Latency: none, wires only.
// Backpressure: in_ready toward producers, out_ready from the consumer.
interface rr_arbiter_mux_if #(
    parameter int N_CH   = 5,
    parameter int DATA_W = 16,
    parameter int ID_W   = $clog2(N_CH)
);
    logic [N_CH-1:0]        in_valid;
    logic [N_CH*DATA_W-1:0] in_data;
    logic [N_CH-1:0]        in_last;
    logic [N_CH-1:0]        in_ready;
    logic                   out_valid;
    logic [DATA_W-1:0]      out_data;
    logic                   out_last;
    logic [ID_W-1:0]        out_id;
    logic                   out_ready;
    logic                   locked;

    // Producers and consumer together drive the master side.
    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last, out_id, locked
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last, out_id, locked
    );
endinterface

// File: rtl/rr_arbiter_mux.sv
// Round-robin N_CH-way arbiter with data mux into one registered output beat, optional packet lock.
// Latency: 1 cycle from input accept to out_valid; 1 beat/cycle sustained.
// Backpressure: while a beat is held and out_ready=0 the output is frozen and in_ready is all zero.
module rr_arbiter_mux #(
    parameter int N_CH    = 5,
    parameter int DATA_W  = 16,
    parameter bit LOCK_EN = 1'b1,
    parameter int ID_W    = $clog2(N_CH)
) (
    input  logic           clk,
    input  logic           reset,
    rr_arbiter_mux_if.slave bus
);

    typedef enum logic {IDLE, LOCK} state_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              last;
        logic [ID_W-1:0]   id;
    } beat_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   lock_id_q, lock_id_d;
    logic [ID_W-1:0]   ptr_q;
    beat_t             out_q;
    logic              out_valid_q;

    logic              load;
    logic              accept;
    logic              any_elig;
    logic [N_CH-1:0]   elig;
    logic [N_CH-1:0]   rot;
    logic [ID_W-1:0]   offset;
    logic [ID_W:0]     sum;
    logic [ID_W-1:0]   winner;
    logic [DATA_W-1:0] win_data;
    logic              win_last;

    assign load = !out_valid_q || bus.out_ready;

    // While locked only the owning channel may compete.
    always_comb begin
        elig = bus.in_valid;
        if (state_q == LOCK) begin
            elig = bus.in_valid & (N_CH'(1) << lock_id_q);
        end
    end

    assign any_elig = |elig;
    assign rot      = N_CH'({elig, elig} >> ptr_q);

    // rot[0] is the channel at ptr; lowest set bit is the winner's distance from ptr.
    always_comb begin
        offset = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (rot[i]) begin
                offset = ID_W'(i);
            end
        end
        sum = {1'b0, ptr_q} + {1'b0, offset};
        if (sum >= (ID_W + 1)'(N_CH)) begin
            sum = sum - (ID_W + 1)'(N_CH);
        end
        winner = sum[ID_W-1:0];
    end

    always_comb begin
        win_data = '0;
        win_last = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (winner == ID_W'(i)) begin
                win_data = bus.in_data[i*DATA_W +: DATA_W];
                win_last = bus.in_last[i];
            end
        end
    end

    assign accept       = load && any_elig;
    assign bus.in_ready = accept ? (N_CH'(1) << winner) : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_q       <= '0;
            ptr_q       <= '0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            out_q       <= '{data: win_data, last: win_last, id: winner};
            ptr_q       <= (winner == ID_W'(N_CH - 1)) ? '0 : winner + ID_W'(1);
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            lock_id_q <= '0;
        end else begin
            state_q   <= state_d;
            lock_id_q <= lock_id_d;
        end
    end

    // A packet opens on a non-last beat and closes on the owner's last beat.
    always_comb begin
        state_d   = state_q;
        lock_id_d = lock_id_q;
        case (state_q)
            IDLE: begin
                if (LOCK_EN && accept && !win_last) begin
                    state_d   = LOCK;
                    lock_id_d = winner;
                end
            end
            LOCK: begin
                if (accept && win_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_q.data;
    assign bus.out_last  = out_q.last;
    assign bus.out_id    = out_q.id;
    assign bus.locked    = (state_q == LOCK);

endmodule

// File: tb/tb_rr_arbiter_mux.sv
// Bench for rr_arbiter_mux: one lock-enabled and one lock-disabled instance fed identical stimulus,
// each scored against its own reference model.
module tb_rr_arbiter_mux;
    localparam int N  = 5;
    localparam int DW = 16;
    localparam int IW = $clog2(N);

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
        logic [IW-1:0] id;
    } beat_t;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    in_valid;
    logic [N-1:0]    in_last;
    logic [N*DW-1:0] in_data;
    logic            out_ready;

    always #5 clk = ~clk;

    rr_arbiter_mux_if #(.N_CH(N), .DATA_W(DW), .ID_W(IW)) bus0 ();
    rr_arbiter_mux_if #(.N_CH(N), .DATA_W(DW), .ID_W(IW)) bus1 ();

    assign bus0.in_valid  = in_valid;
    assign bus0.in_data   = in_data;
    assign bus0.in_last   = in_last;
    assign bus0.out_ready = out_ready;
    assign bus1.in_valid  = in_valid;
    assign bus1.in_data   = in_data;
    assign bus1.in_last   = in_last;
    assign bus1.out_ready = out_ready;

    rr_arbiter_mux #(.N_CH(N), .DATA_W(DW), .LOCK_EN(1'b1), .ID_W(IW)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0));
    rr_arbiter_mux #(.N_CH(N), .DATA_W(DW), .LOCK_EN(1'b0), .ID_W(IW)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1));

    int    n_chk  = 0;
    int    n_fail = 0;
    beat_t q0[$];
    beat_t q1[$];
    int    m_ptr[2];
    bit    m_lock[2];
    int    m_lock_id[2];
    bit    m_ov[2];

    task automatic chk(string name, int u, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d at %0t: got %0h expected %0h", name, u, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int u = 0; u < 2; u++) begin
            m_ptr[u] = 0; m_lock[u] = 0; m_lock_id[u] = 0; m_ov[u] = 0;
        end
        q0.delete();
        q1.delete();
    endtask

    // Reference: first valid eligible channel scanning from ptr; lock restricts to the owner.
    task automatic model_step(int u, bit lock_en, logic [N-1:0] rdy, logic ov, logic lk);
        int          win;
        bit          load;
        logic [N-1:0] exp_rdy;
        beat_t       b;
        chk("out_valid", u, 32'(ov), 32'(m_ov[u]));
        chk("locked", u, 32'(lk), 32'(m_lock[u]));
        load = !m_ov[u] || out_ready;
        win  = -1;
        for (int k = 0; k < N; k++) begin
            int c;
            c = (m_ptr[u] + k) % N;
            if (win < 0 && ((in_valid >> c) & 1) != 0 && (!m_lock[u] || c == m_lock_id[u]))
                win = c;
        end
        exp_rdy = '0;
        if (load && win >= 0) exp_rdy = N'(1) << win;
        chk("in_ready", u, 32'(rdy), 32'(exp_rdy));
        if (load && win >= 0) begin
            b.data = DW'(in_data >> (win * DW));
            b.last = ((in_last >> win) & 1) != 0;
            b.id   = IW'(win);
            if (u == 0) q0.push_back(b);
            else        q1.push_back(b);
            m_ptr[u] = (win + 1) % N;
            if (lock_en) begin
                if (!m_lock[u] && !b.last) begin
                    m_lock[u]    = 1;
                    m_lock_id[u] = win;
                end else if (m_lock[u] && b.last) begin
                    m_lock[u] = 0;
                end
            end
            m_ov[u] = 1;
        end else if (out_ready) begin
            m_ov[u] = 0;
        end
    endtask

    task automatic mon(int u, beat_t act);
        beat_t e;
        bit    empty;
        empty = (u == 0) ? (q0.size() == 0) : (q1.size() == 0);
        if (empty) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_beat dut%0d at %0t: got %0h expected none", u, $time, act);
        end else begin
            e = (u == 0) ? q0.pop_front() : q1.pop_front();
            chk("beat", u, 32'(act), 32'(e));
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            model_step(0, 1'b1, bus0.in_ready, bus0.out_valid, bus0.locked);
            model_step(1, 1'b0, bus1.in_ready, bus1.out_valid, bus1.locked);
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (bus0.out_valid && out_ready) mon(0, {bus0.out_data, bus0.out_last, bus0.out_id});
            if (bus1.out_valid && out_ready) mon(1, {bus1.out_data, bus1.out_last, bus1.out_id});
        end
    end

    task automatic cyc(logic [N-1:0] v, logic [N-1:0] l, logic [DW-1:0] base, logic ordy);
        @(posedge clk);
        #1;
        in_valid  = v;
        in_last   = l;
        out_ready = ordy;
        for (int k = 0; k < N; k++) in_data[k*DW +: DW] = base + DW'(k);
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = '0;
        in_last   = '0;
        in_data   = '0;
        out_ready = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 0, 32'(bus0.out_valid), 0);
        chk("rst_out_valid", 1, 32'(bus1.out_valid), 0);
        chk("rst_in_ready", 0, 32'(bus0.in_ready), 0);
        chk("rst_in_ready", 1, 32'(bus1.in_ready), 0);
        chk("rst_out_id", 0, 32'(bus0.out_id), 0);
        chk("rst_out_data", 0, 32'(bus0.out_data), 0);
        chk("rst_locked", 0, 32'(bus0.locked), 0);
        chk("rst_locked", 1, 32'(bus1.locked), 0);
        reset = 1'b0;

        // All channels valid, single-beat packets: ids rotate 0..4,0.
        repeat (6) cyc(5'h1F, 5'h1F, 16'h1000, 1'b1);
        repeat (2) cyc(5'h1F, 5'h1F, 16'h1000, 1'b1);
        repeat (4) cyc(5'h1F, 5'h1F, 16'h1000, 1'b0);
        cyc(5'h1F, 5'h1F, 16'h1000, 1'b1);
        // Steer ptr to 2, then a 3-beat ch2 packet with a valid gap while ch1/ch3 wait.
        cyc(5'h02, 5'h1F, 16'h1100, 1'b1);
        cyc(5'h0E, 5'h1B, 16'h2000, 1'b1);
        cyc(5'h0E, 5'h1B, 16'h2010, 1'b1);
        cyc(5'h0A, 5'h1B, 16'h2020, 1'b1);
        cyc(5'h0E, 5'h1F, 16'h2030, 1'b1);
        cyc(5'h0A, 5'h1F, 16'h2040, 1'b1);
        cyc(5'h0A, 5'h1F, 16'h2050, 1'b1);
        cyc(5'h00, 5'h1F, 16'h2060, 1'b1);
        // Wrap: grant ch4, then ch0 must precede ch4.
        cyc(5'h10, 5'h1F, 16'h3000, 1'b1);
        cyc(5'h11, 5'h1F, 16'h3010, 1'b1);
        cyc(5'h11, 5'h1F, 16'h3020, 1'b1);

        for (int i = 0; i < 1500; i++) begin
            cyc(N'($urandom), N'($urandom | $urandom), DW'($urandom), $urandom_range(0, 3) != 0);
        end

        // Open a ch2 packet, stall, then reset asynchronously mid-cycle.
        cyc(5'h04, 5'h00, 16'h4000, 1'b1);
        cyc(5'h04, 5'h00, 16'h4010, 1'b0);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("async_rst_out_valid", 0, 32'(bus0.out_valid), 0);
        chk("async_rst_out_valid", 1, 32'(bus1.out_valid), 0);
        chk("async_rst_locked", 0, 32'(bus0.locked), 0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (3) cyc(5'h1F, 5'h1F, 16'h5000, 1'b1);
        repeat (4) cyc(5'h00, 5'h00, 16'h0000, 1'b1);
        @(negedge clk);
        #1;
        chk("drain_q", 0, 32'(q0.size()), 0);
        chk("drain_q", 1, 32'(q1.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/rr_arbiter_mux.md
Name: rr_arbiter_mux

Overview:
- Parametrised round-robin N-channel arbiter with data multiplexer and a registered output stage.
- Successor of the team's fixed 5-channel arbiter mux. Adds generic channel count and data width, valid/ready handshakes on both sides, and optional packet lock so multi-beat transfers are never interleaved.
- Sits between N producer ports and a single shared downstream consumer (bus or link).

Parameters:
- N_CH, 5, number of request channels (2..16)
- DATA_W, 16, payload width per channel
- LOCK_EN, 1, 1 = hold grant until beat with last=1 accepted; 0 = re-arbitrate every beat
- ID_W, $clog2(N_CH), width of channel id output

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- in_valid  input  N_CH  per-channel beat valid
- in_data  input  N_CH*DATA_W  per-channel payload, channel k at bits [k*DATA_W +: DATA_W]
- in_last  input  N_CH  per-channel end-of-packet marker
- in_ready  output  N_CH  per-channel accept, one-hot or zero
- out_valid  output  1  registered beat valid
- out_data  output  DATA_W  registered payload
- out_last  output  1  registered end-of-packet
- out_id  output  ID_W  channel index of registered beat
- out_ready  input  1  downstream accept
- locked  output  1  packet lock active

Behaviour:
- Interface: reset reset, asynchronous, active-high; clock clk.
- Reset values:
  - out_valid=0, out_data=0, out_last=0, out_id=0, locked=0.
  - Priority pointer ptr=0, so channel 0 has highest priority.
  - in_ready is combinational and evaluates to 0 while out_valid=0 and no in_valid is set.
- load = !out_valid | out_ready. The output register is free this cycle.
- Eligible set:
  - When unlocked: all channels with in_valid=1.
  - When locked: only lock_id, and only if in_valid[lock_id]=1.
- Winner: the first eligible channel scanning ptr, ptr+1, ... mod N_CH.
- in_ready[winner]=1 only when load=1 and the eligible set is non-empty. All other in_ready bits are 0.
  - in_ready depends combinationally on in_valid and out_ready. It must not depend on in_data.
- Beat accept (in_valid&in_ready):
  - Next edge: out_data, out_last, out_id take the winner's values; out_valid=1.
  - ptr becomes (winner+1) mod N_CH, wrapping from N_CH-1 to 0.
  - Latency is 1 cycle from accept to out_valid.
- No accept and out_ready=1: out_valid goes to 0 next edge. out_data, out_last and out_id hold their last value.
- out_valid=1 and out_ready=0: out_data, out_last and out_id are stable and in_ready is all zeros. The output never changes while stalled.
- Throughput: 1 beat per cycle when out_ready is held at 1.
- Lock state machine (LOCK_EN=1), states IDLE and LOCK:
  - IDLE -> LOCK on accept with in_last=0. lock_id is set to the winner.
  - LOCK -> IDLE on accept from lock_id with in_last=1.
  - In LOCK, a gap in in_valid[lock_id] produces bubbles. Other channels stay blocked.
  - locked=1 in LOCK.
- Pointer behaviour under lock: ptr still advances per accept, so after a packet ends the next priority goes to lock_id+1.
- LOCK_EN=0: the state machine stays in IDLE, locked=0, and in_last is only forwarded.
- Simultaneous out_ready and new accept: the old beat is consumed and the new beat is loaded in the same edge, with no bubble.
- Reset mid-packet: lock is cleared, ptr=0, and the output register is invalidated immediately (asynchronous). A partially transferred packet is dropped at this block.
- Single channel requesting: it wins every cycle regardless of ptr.

Test Plan:
1. Reset, then all in_valid=0 and out_ready=1 -> out_valid=0, in_ready=00000, out_id=0, locked=0. Assert reset mid-stream -> out_valid drops to 0 without waiting for a clock edge.
2. N_CH=5, all channels valid, in_last=1, data k=0x1000+k, out_ready=1 -> out_id sequence 0,1,2,3,4,0 on consecutive cycles, out_data 0x1000..0x1004, one beat per cycle.
3. Backpressure: out_ready=0 for 4 cycles with beat 0x1002 held -> out_data stays 0x1002, in_ready=0. out_ready rises -> next beat from ch3 appears one cycle later, with no loss and no duplicate.
4. Lock: ch2 sends 3 beats (last=0,0,1) while ch1 and ch3 are valid; ch2 drops valid for 1 cycle mid-packet -> out_id 2,2,(bubble),2 with locked=1 throughout, then ch3 is granted, then ch1.
5. Wrap: after a grant to ch4, ch4 and ch0 both request -> ch0 granted first, then ch4.
6. LOCK_EN=0, same stimulus as scenario 4 -> ch2 beats interleave with ch3/ch1 in round-robin order, locked stays 0.
